// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and commit, out-of-order completion
// via the CDB, two operand query ports with CDB bypass, and alias-table update ports.
module reorder_buffer #(
  parameter int ROB_ENTRY       = 4,
  parameter int ARCH_ENTRY      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
  parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [ARCH_ENTRY_LOG2-1:0]   alloc_arch_id,
  input  logic                         alloc_has_dest,
  output logic [ROB_ENTRY_LOG2-1:0]    alloc_rob_id,
  output logic                         rat_register_request,
  output logic [ARCH_ENTRY_LOG2-1:0]   rat_register_arch_id,
  output logic [ROB_ENTRY_LOG2-1:0]    rat_register_alias,
  output logic                         rat_register_remove,
  input  logic                         cdb_valid,
  input  logic [ROB_ENTRY_LOG2-1:0]    cdb_rob_id,
  input  logic [DATA_WIDTH-1:0]        cdb_data,
  input  logic [2*ROB_ENTRY_LOG2-1:0]  query_rob_id,
  output logic [1:0]                   query_ready,
  output logic [2*DATA_WIDTH-1:0]      query_data,
  output logic                         commit_valid,
  input  logic                         commit_ready,
  output logic [ARCH_ENTRY_LOG2-1:0]   commit_arch_id,
  output logic                         commit_we,
  output logic [DATA_WIDTH-1:0]        commit_data,
  input  logic                         flush
);

  localparam logic [ROB_ENTRY_LOG2:0]   FULL_COUNT = (ROB_ENTRY_LOG2+1)'(ROB_ENTRY);
  localparam logic [ROB_ENTRY_LOG2:0]   CNT_ONE    = (ROB_ENTRY_LOG2+1)'(1);
  localparam logic [ROB_ENTRY_LOG2-1:0] PTR_ONE    = ROB_ENTRY_LOG2'(1);

  logic [ROB_ENTRY-1:0]       valid_q, valid_d, done_q, done_d;
  logic [ROB_ENTRY-1:0]       has_dest_q, has_dest_d, latest_q, latest_d;
  logic [ARCH_ENTRY_LOG2-1:0] arch_id_q [ROB_ENTRY];
  logic [ARCH_ENTRY_LOG2-1:0] arch_id_d [ROB_ENTRY];
  logic [DATA_WIDTH-1:0]      data_q [ROB_ENTRY];
  logic [DATA_WIDTH-1:0]      data_d [ROB_ENTRY];
  logic [ROB_ENTRY_LOG2-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ROB_ENTRY_LOG2:0]    count_q, count_d;

  logic run_s, alloc_dest_s, alloc_fire_s, commit_fire_s, head_renamed_s;

  // Reset also masks the request/commit/query outputs so they are quiet immediately.
  assign run_s         = RSTN && !flush;
  assign alloc_ready   = (count_q < FULL_COUNT);
  assign alloc_rob_id  = tail_q;
  assign alloc_dest_s  = alloc_has_dest && (alloc_arch_id != '0);
  assign alloc_fire_s  = alloc_valid && alloc_ready && run_s;

  assign rat_register_request = alloc_fire_s && alloc_dest_s;
  assign rat_register_arch_id = alloc_arch_id;
  assign rat_register_alias   = tail_q;

  assign commit_valid   = run_s && valid_q[head_q] && done_q[head_q];
  assign commit_fire_s  = commit_valid && commit_ready;
  assign commit_we      = has_dest_q[head_q];
  assign commit_arch_id = arch_id_q[head_q];
  assign commit_data    = data_q[head_q];

  // A same-cycle younger writer of the head's register steals the alias.
  assign head_renamed_s = alloc_fire_s && alloc_dest_s && (arch_id_q[head_q] == alloc_arch_id);
  assign rat_register_remove = commit_fire_s && has_dest_q[head_q] && latest_q[head_q] && !head_renamed_s;

  for (genvar k = 0; k < 2; k++) begin : g_query
    logic [ROB_ENTRY_LOG2-1:0] qid_s;
    logic                      hit_s;
    assign qid_s = query_rob_id[k*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
    assign hit_s = cdb_valid && (cdb_rob_id == qid_s);
    assign query_ready[k] = RSTN && (done_q[qid_s] || hit_s);
    assign query_data[k*DATA_WIDTH +: DATA_WIDTH] = hit_s ? cdb_data : data_q[qid_s];
  end

  // Next-state: flush wins, otherwise completion, commit and allocation in that order.
  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    has_dest_d = has_dest_q;
    latest_d   = latest_q;
    arch_id_d  = arch_id_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_valid && valid_q[cdb_rob_id]) begin
        done_d[cdb_rob_id] = 1'b1;
        data_d[cdb_rob_id] = cdb_data;
      end else begin
        done_d = done_d;
      end
      if (commit_fire_s) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (alloc_fire_s) begin
        for (int i = 0; i < ROB_ENTRY; i++) begin
          if (alloc_dest_s && valid_q[i] && (arch_id_q[i] == alloc_arch_id)) begin
            latest_d[i] = 1'b0;
          end else begin
            latest_d[i] = latest_d[i];
          end
        end
        valid_d[tail_q]    = 1'b1;
        done_d[tail_q]     = 1'b0;
        has_dest_d[tail_q] = alloc_dest_s;
        latest_d[tail_q]   = alloc_dest_s;
        arch_id_d[tail_q]  = alloc_arch_id;
        tail_d             = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q    <= '0;
      done_q     <= '0;
      has_dest_q <= '0;
      latest_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < ROB_ENTRY; i++) begin
        arch_id_q[i] <= '0;
        data_q[i]    <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      has_dest_q <= has_dest_d;
      latest_q   <= latest_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      arch_id_q  <= arch_id_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table, directed corner sequences,
// and randomized traffic against a program-order queue model.
module tb_reorder_buffer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        alloc_valid, alloc_ready, alloc_has_dest;
  logic [4:0]  alloc_arch_id;
  logic [1:0]  alloc_rob_id;
  logic        rat_register_request, rat_register_remove;
  logic [4:0]  rat_register_arch_id;
  logic [1:0]  rat_register_alias;
  logic        cdb_valid;
  logic [1:0]  cdb_rob_id;
  logic [31:0] cdb_data;
  logic [3:0]  query_rob_id;
  logic [1:0]  query_ready;
  logic [63:0] query_data;
  logic        commit_valid, commit_ready, commit_we;
  logic [4:0]  commit_arch_id;
  logic [31:0] commit_data;
  logic        flush;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .CLK(CLK), .RSTN(RSTN),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_arch_id(alloc_arch_id),
    .alloc_has_dest(alloc_has_dest), .alloc_rob_id(alloc_rob_id),
    .rat_register_request(rat_register_request), .rat_register_arch_id(rat_register_arch_id),
    .rat_register_alias(rat_register_alias), .rat_register_remove(rat_register_remove),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .query_rob_id(query_rob_id), .query_ready(query_ready), .query_data(query_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_arch_id(commit_arch_id),
    .commit_we(commit_we), .commit_data(commit_data), .flush(flush)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_arch_id = 5'd0; alloc_has_dest = 1'b0;
    cdb_valid = 1'b0; cdb_rob_id = 2'd0; cdb_data = 32'd0;
    query_rob_id = 4'd0; commit_ready = 1'b0; flush = 1'b0;
  endtask

  // Advance one edge; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RSTN = 1'b0;
    tick();
    tick();
    RSTN = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] arch);
    idle();
    alloc_valid = 1'b1; alloc_arch_id = arch; alloc_has_dest = 1'b1;
    tick();
  endtask

  task automatic complete(input logic [1:0] id, input logic [31:0] d);
    idle();
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_data = d;
    tick();
  endtask

  typedef struct {
    logic av; logic [4:0] arch; logic cv; logic [1:0] cid; logic [31:0] cdata; logic cr;
    logic e_ar; logic [1:0] e_rid; logic e_req; logic e_cv; logic e_rm;
    logic [4:0] e_carch; logic [31:0] e_cdata;
  } vec_t;
  vec_t vecs[11];

  typedef struct {
    logic [4:0] arch; logic hd; logic done; logic [31:0] data; logic [1:0] id;
  } ment_t;
  ment_t mq[$];
  logic [1:0] m_head;

  function automatic int find(input logic [1:0] id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  initial begin
    // Fill, refuse a fifth, then out-of-order completion and in-order commit.
    vecs[0]  = '{1'b1, 5'd1, 1'b0, 2'd0, 32'h0,  1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[1]  = '{1'b1, 5'd2, 1'b0, 2'd0, 32'h0,  1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{1'b1, 5'd3, 1'b0, 2'd0, 32'h0,  1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[3]  = '{1'b1, 5'd4, 1'b0, 2'd0, 32'h0,  1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[4]  = '{1'b1, 5'd5, 1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0, 1'b1, 2'd2, 32'h22, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 1'b1, 2'd0, 32'h11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[7]  = '{1'b0, 5'd0, 1'b1, 2'd1, 32'h33, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11};
    vecs[8]  = '{1'b0, 5'd0, 1'b0, 2'd0, 32'h0,  1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h33};
    vecs[9]  = '{1'b0, 5'd0, 1'b0, 2'd0, 32'h0,  1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h22};
    vecs[10] = '{1'b0, 5'd0, 1'b0, 2'd0, 32'h0,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

    do_reset();
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_rob_id", alloc_rob_id, 0);
    chk("reset_commit_valid", commit_valid, 0);

    foreach (vecs[i]) begin
      idle();
      alloc_valid = vecs[i].av; alloc_arch_id = vecs[i].arch; alloc_has_dest = vecs[i].av;
      cdb_valid = vecs[i].cv; cdb_rob_id = vecs[i].cid; cdb_data = vecs[i].cdata;
      commit_ready = vecs[i].cr;
      #1;
      chk($sformatf("vec%0d_alloc_ready", i), alloc_ready, vecs[i].e_ar);
      chk($sformatf("vec%0d_rob_id", i), alloc_rob_id, vecs[i].e_rid);
      chk($sformatf("vec%0d_request", i), rat_register_request, vecs[i].e_req);
      chk($sformatf("vec%0d_commit_valid", i), commit_valid, vecs[i].e_cv);
      chk($sformatf("vec%0d_remove", i), rat_register_remove, vecs[i].e_rm);
      if (vecs[i].e_cv) begin
        chk($sformatf("vec%0d_commit_arch", i), commit_arch_id, vecs[i].e_carch);
        chk($sformatf("vec%0d_commit_data", i), commit_data, vecs[i].e_cdata);
      end
      if (vecs[i].e_req) chk($sformatf("vec%0d_alias", i), rat_register_alias, vecs[i].e_rid);
      tick();
    end

    // Rename overlap: older x5 must not remove the alias held by the younger x5.
    do_reset();
    alloc(5'd5);
    alloc(5'd5);
    complete(2'd0, 32'h50);
    complete(2'd1, 32'h51);
    idle(); commit_ready = 1'b1; #1;
    chk("rename_cv0", commit_valid, 1);
    chk("rename_data0", commit_data, 32'h50);
    chk("rename_remove0", rat_register_remove, 0);
    tick();
    idle(); commit_ready = 1'b1; #1;
    chk("rename_data1", commit_data, 32'h51);
    chk("rename_remove1", rat_register_remove, 1);
    tick();

    // Bypass: id3 matches the CDB this cycle, id2 was never completed.
    idle();
    cdb_valid = 1'b1; cdb_rob_id = 2'd3; cdb_data = 32'hDEADBEEF; query_rob_id = {2'd2, 2'd3};
    #1;
    chk("bypass_ready0", query_ready[0], 1);
    chk("bypass_data0", query_data[31:0], 32'hDEADBEEF);
    chk("bypass_ready1", query_ready[1], 0);
    tick();

    // Full plus commit: commit proceeds, allocation refused, next cycle accepted at id0.
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd3); alloc(5'd4);
    complete(2'd0, 32'hA0);
    idle(); alloc_valid = 1'b1; alloc_arch_id = 5'd9; alloc_has_dest = 1'b1; commit_ready = 1'b1;
    #1;
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_commit_valid", commit_valid, 1);
    chk("full_request", rat_register_request, 0);
    tick();
    idle(); alloc_valid = 1'b1; alloc_arch_id = 5'd9; alloc_has_dest = 1'b1;
    #1;
    chk("full_next_ready", alloc_ready, 1);
    chk("full_next_rob_id", alloc_rob_id, 0);
    chk("full_next_request", rat_register_request, 1);
    tick();
    idle(); #1;
    chk("full_again", alloc_ready, 0);

    // Flush with three entries and a done head.
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    complete(2'd0, 32'hB0);
    idle(); flush = 1'b1; commit_ready = 1'b1; alloc_valid = 1'b1; alloc_arch_id = 5'd4; alloc_has_dest = 1'b1;
    #1;
    chk("flush_cv_masked", commit_valid, 0);
    chk("flush_remove_masked", rat_register_remove, 0);
    chk("flush_request_masked", rat_register_request, 0);
    tick();
    idle(); commit_ready = 1'b1; #1;
    chk("post_flush_cv", commit_valid, 0);
    chk("post_flush_rob_id", alloc_rob_id, 0);
    chk("post_flush_ready", alloc_ready, 1);

    // Asynchronous reset in the middle of a commit.
    alloc(5'd7); alloc(5'd8);
    complete(2'd0, 32'hC0);
    idle(); commit_ready = 1'b1; alloc_valid = 1'b1; alloc_arch_id = 5'd7; alloc_has_dest = 1'b1;
    cdb_valid = 1'b1; cdb_rob_id = 2'd1; query_rob_id = {2'd0, 2'd1};
    #1;
    chk("pre_reset_cv", commit_valid, 1);
    #1 RSTN = 1'b0;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_rob_id", alloc_rob_id, 0);
    chk("rst_cv", commit_valid, 0);
    chk("rst_request", rat_register_request, 0);
    chk("rst_remove", rat_register_remove, 0);
    chk("rst_query_ready", query_ready, 2'b00);
    idle();
    tick();
    RSTN = 1'b1;

    // Randomized traffic against the program-order queue model.
    mq.delete();
    m_head = 2'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [1:0] tail;
      logic hd, afire, cfire, exp_rm, exp_cv, bp;
      int idx;
      idle();
      alloc_valid    = ($urandom_range(0, 2) != 0);
      alloc_arch_id  = 5'($urandom_range(0, 6));
      alloc_has_dest = ($urandom_range(0, 4) != 0);
      cdb_valid      = ($urandom_range(0, 1) == 1);
      cdb_rob_id     = 2'($urandom_range(0, 3));
      cdb_data       = $urandom;
      commit_ready   = ($urandom_range(0, 3) != 0);
      query_rob_id   = 4'($urandom_range(0, 15));
      flush          = ($urandom_range(0, 29) == 0);
      #1;
      tail  = m_head + 2'(mq.size());
      hd    = alloc_has_dest && (alloc_arch_id != 5'd0);
      afire = alloc_valid && (mq.size() < 4) && !flush;
      chk("rnd_alloc_ready", alloc_ready, (mq.size() < 4));
      chk("rnd_rob_id", alloc_rob_id, tail);
      chk("rnd_request", rat_register_request, afire && hd);
      if (afire && hd) begin
        chk("rnd_rat_arch", rat_register_arch_id, alloc_arch_id);
        chk("rnd_alias", rat_register_alias, tail);
      end
      exp_cv = !flush && (mq.size() > 0) && mq[0].done;
      chk("rnd_commit_valid", commit_valid, exp_cv);
      cfire  = exp_cv && commit_ready;
      exp_rm = 1'b0;
      if (exp_cv) begin
        chk("rnd_commit_arch", commit_arch_id, mq[0].arch);
        chk("rnd_commit_we", commit_we, mq[0].hd);
        chk("rnd_commit_data", commit_data, mq[0].data);
        exp_rm = cfire && mq[0].hd && !(afire && hd && alloc_arch_id == mq[0].arch);
        for (int j = 1; j < mq.size(); j++)
          if (mq[j].hd && mq[j].arch == mq[0].arch) exp_rm = 1'b0;
      end
      chk("rnd_remove", rat_register_remove, exp_rm);
      for (int k = 0; k < 2; k++) begin
        logic [1:0] qid;
        qid = query_rob_id[k*2 +: 2];
        idx = find(qid);
        bp  = cdb_valid && (cdb_rob_id == qid);
        if (bp || idx >= 0) begin
          chk("rnd_query_ready", query_ready[k], bp || mq[idx].done);
          if (bp) chk("rnd_query_bypass", query_data[k*32 +: 32], cdb_data);
          else if (mq[idx].done) chk("rnd_query_data", query_data[k*32 +: 32], mq[idx].data);
        end
      end
      if (flush) begin
        mq.delete();
        m_head = 2'd0;
      end else begin
        if (cdb_valid) begin
          idx = find(cdb_rob_id);
          if (idx >= 0) begin
            mq[idx].done = 1'b1;
            mq[idx].data = cdb_data;
          end
        end
        if (cfire) begin
          void'(mq.pop_front());
          m_head = m_head + 2'd1;
        end
        if (afire) mq.push_back('{alloc_arch_id, hd, 1'b0, 32'd0, tail});
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
